// File: rtl/lcd_ctrl.sv
// Character-LCD sequencer for the Spartan-3E starter board (HD44780, 4-bit bus).
// Runs the power-on/4-bit init sequence after reset, then writes one CPU byte at
// a time as two nibble strobes (setup, E pulse, gap) followed by a settle wait.
module lcd_ctrl #(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_4MS   = 205000,
  parameter int unsigned T_100US = 5000,
  parameter int unsigned T_40US  = 2000,
  parameter int unsigned T_1MS64 = 82000,
  parameter int unsigned T_SU    = 2,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_GAP   = 50
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       init_done,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SETUP, PULSE, GAP, SETTLE
  } state_t;

  // Counter reload values: a wait of N clocks loads N-1 and ends on zero.
  localparam logic [19:0] CNT_PWR   = 20'(T_PWR - 1);
  localparam logic [19:0] CNT_4MS   = 20'(T_4MS - 1);
  localparam logic [19:0] CNT_100US = 20'(T_100US - 1);
  localparam logic [19:0] CNT_40US  = 20'(T_40US - 1);
  localparam logic [19:0] CNT_1MS64 = 20'(T_1MS64 - 1);
  localparam logic [19:0] CNT_SU    = 20'(T_SU - 1);
  localparam logic [19:0] CNT_E     = 20'(T_E - 1);
  localparam logic [19:0] CNT_GAP   = 20'(T_GAP - 1);
  localparam logic [3:0]  LAST_STEP = 4'd11;

  // Init nibble list: 3,3,3,2 wake-up, then 0x28, 0x06, 0x0C, 0x01 as nibble pairs.
  function automatic logic [3:0] init_nib(input logic [3:0] step);
    case (step)
      4'd0, 4'd1, 4'd2: init_nib = 4'h3;
      4'd3, 4'd4:       init_nib = 4'h2;
      4'd5:             init_nib = 4'h8;
      4'd7:             init_nib = 4'h6;
      4'd9:             init_nib = 4'hC;
      4'd11:            init_nib = 4'h1;
      default:          init_nib = 4'h0;
    endcase
  endfunction

  // Upper halves of the init bytes (steps 4,6,8,10) run straight into their lower half.
  function automatic logic init_has_wait(input logic [3:0] step);
    init_has_wait = (step < 4'd4) || step[0];
  endfunction

  function automatic logic [19:0] init_wait(input logic [3:0] step);
    case (step)
      4'd0:             init_wait = CNT_4MS;
      4'd1, 4'd2, 4'd3: init_wait = CNT_100US;
      4'd11:            init_wait = CNT_1MS64;
      default:          init_wait = CNT_40US;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  step_q, step_d;
  logic        armed_q, armed_d;
  logic        low_q, low_d;
  logic [7:0]  byte_q, byte_d;
  logic [3:0]  sf_d_q, sf_d_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_e_q, lcd_e_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        init_done_q, init_done_d;
  logic        is_clear;

  // Clear (0x01) and return-home (0x02/0x03) commands need the long settle.
  assign is_clear = !lcd_rs_q && (byte_q <= 8'h03);

  // Next-state, counter and registered-output decisions.
  always_comb begin
    // NOTE: every variable gets its hold/default value first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    armed_d     = armed_q;
    low_d       = low_q;
    byte_d      = byte_q;
    sf_d_d      = sf_d_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_e_d     = lcd_e_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    init_done_d = init_done_q;

    case (state_q)
      PWR_WAIT: begin
        if (!armed_q) begin
          // Counter comes out of reset cleared; load the power-on wait once.
          armed_d = 1'b1;
          cnt_d   = CNT_PWR;
        end else if (cnt_q == '0) begin
          state_d  = INIT_NIB;
          sf_d_d   = init_nib(4'd0);
          lcd_rs_d = 1'b0;
          cnt_d    = CNT_SU;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      INIT_NIB, SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          lcd_e_d = 1'b1;
          cnt_d   = CNT_E;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          lcd_e_d = 1'b0;
          cnt_d   = CNT_GAP;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 20'd1;
        end else if (!init_done_q) begin
          if (init_has_wait(step_q)) begin
            state_d = INIT_WAIT;
            cnt_d   = init_wait(step_q);
          end else begin
            state_d = INIT_NIB;
            step_d  = step_q + 4'd1;
            sf_d_d  = init_nib(step_q + 4'd1);
            cnt_d   = CNT_SU;
          end
        end else if (!low_q) begin
          state_d = SETUP;
          low_d   = 1'b1;
          sf_d_d  = byte_q[3:0];
          cnt_d   = CNT_SU;
        end else begin
          state_d = SETTLE;
          cnt_d   = is_clear ? CNT_1MS64 : CNT_40US;
        end
      end

      INIT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 20'd1;
        end else if (step_q == LAST_STEP) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          ready_d     = 1'b1;
        end else begin
          state_d = INIT_NIB;
          step_d  = step_q + 4'd1;
          sf_d_d  = init_nib(step_q + 4'd1);
          cnt_d   = CNT_SU;
        end
      end

      IDLE: begin
        if (req && ready_q) begin
          state_d  = SETUP;
          byte_d   = data;
          lcd_rs_d = rs;
          sf_d_d   = data[7:4];
          low_d    = 1'b0;
          ready_d  = 1'b0;
          cnt_d    = CNT_SU;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      default: state_d = PWR_WAIT;
    endcase
  end

  // State and output registers; reset aborts any transfer and restarts init.
  // NOTE: asynchronous reset drops LCD_E immediately, without waiting for a clock edge.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      step_q      <= '0;
      armed_q     <= 1'b0;
      low_q       <= 1'b0;
      byte_q      <= '0;
      sf_d_q      <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      armed_q     <= armed_d;
      low_q       <= low_d;
      byte_q      <= byte_d;
      sf_d_q      <= sf_d_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign init_done = init_done_q;
  assign SF_D      = sf_d_q;
  assign LCD_E     = lcd_e_q;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl with shortened timing. Stimulus pushes the
// expected nibble strobes and done delays; a monitor pops them as the DUT
// produces E pulses and done pulses.
module tb_lcd_ctrl;

  localparam int T_PWR   = 20;
  localparam int T_4MS   = 10;
  localparam int T_100US = 5;
  localparam int T_40US  = 4;
  localparam int T_1MS64 = 8;
  localparam int T_SU    = 1;
  localparam int T_E     = 2;
  localparam int T_GAP   = 3;

  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
  } nib_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [7:0] settle;
    logic       poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, done, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] sf_d;

  nib_t exp_nib_q[$];
  int   exp_done_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_high = -1000;
  int first_rise = -1;
  int rel_cyc = 0;

  lcd_ctrl #(
    .T_PWR(T_PWR), .T_4MS(T_4MS), .T_100US(T_100US), .T_40US(T_40US),
    .T_1MS64(T_1MS64), .T_SU(T_SU), .T_E(T_E), .T_GAP(T_GAP)
  ) dut (
    .CLK_50MHZ(clk),
    .RST_N(rst_n),
    .req(req),
    .rs(rs),
    .data(data),
    .ready(ready),
    .done(done),
    .init_done(init_done),
    .SF_D(sf_d),
    .LCD_E(lcd_e),
    .LCD_RS(lcd_rs),
    .LCD_RW(lcd_rw)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Step to just after the falling edge, once the monitor has sampled it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_init();
    logic [3:0] nibs [12];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    for (int i = 0; i < 12; i++) exp_nib_q.push_back('{rs: 1'b0, nib: nibs[i]});
  endtask

  // Done is expected 1 + T_GAP + settle samples after the last E-high sample.
  task automatic push_byte(input logic b_rs, input logic [7:0] b_data, input int settle);
    exp_nib_q.push_back('{rs: b_rs, nib: b_data[7:4]});
    exp_nib_q.push_back('{rs: b_rs, nib: b_data[3:0]});
    exp_done_q.push_back(1 + T_GAP + settle);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 3000) begin
      tick();
      n++;
    end
    if (!ready) fail_now(name);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    if (!done) fail_now(name);
  endtask

  task automatic wait_init(input string name);
    int   n = 0;
    logic prev_ready = 1'b0;
    while (!init_done && n < 3000) begin
      prev_ready = ready;
      tick();
      n++;
    end
    if (!init_done) begin
      fail_now(name);
    end else begin
      check({name, "_ready_before"}, prev_ready, 1'b0);
      check({name, "_ready_with_init_done"}, ready, 1'b1);
      check({name, "_final_settle"}, cyc - last_high, 1 + T_GAP + T_1MS64);
      check({name, "_first_rise_delay_ok"}, (first_rise - rel_cyc) >= 21, 1'b1);
    end
  endtask

  task automatic send(input vec_t v);
    wait_ready("send_wait_ready");
    push_byte(v.rs, v.data, int'(v.settle));
    rs   = v.rs;
    data = v.data;
    req  = 1'b1;
    tick();
    req  = 1'b0;
    check("accept_ready_low", ready, 1'b0);
    check("accept_upper_nib", sf_d, v.data[7:4]);
    check("accept_rs", lcd_rs, v.rs);
    // Inputs changed after acceptance must not disturb the transfer.
    rs   = ~v.rs;
    data = 8'hA5;
    if (v.poke) begin
      repeat (2) tick();
      req = 1'b1;
      repeat (4) tick();
      req = 1'b0;
    end
    wait_done("send_wait_done");
  endtask

  // Monitor: pops one expected nibble per E pulse and one delay per done pulse.
  initial begin
    int   width = 0;
    logic in_pulse = 1'b0;
    nib_t e;
    int   g;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_pulse   = 1'b0;
        first_rise = -1;
      end else begin
        if (lcd_e && !in_pulse) begin
          in_pulse = 1'b1;
          width    = 0;
          if (first_rise < 0) first_rise = cyc;
          check("e_low_spacing_ok", (cyc - last_high - 1) >= (T_GAP + T_SU), 1'b1);
          if (exp_nib_q.size() == 0) begin
            fail_now("unexpected_e_pulse");
          end else begin
            e = exp_nib_q.pop_front();
            check("nibble", sf_d, e.nib);
            check("nibble_rs", lcd_rs, e.rs);
            check("rw_low", lcd_rw, 1'b0);
          end
        end
        if (lcd_e) begin
          width++;
          last_high = cyc;
        end else if (in_pulse) begin
          in_pulse = 1'b0;
          check("e_width", width, T_E);
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            g = exp_done_q.pop_front();
            check("done_delay", cyc - last_high, g);
            check("ready_with_done", ready, 1'b1);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    vecs = '{
      '{rs: 1'b1, data: 8'h41, settle: 8'd4, poke: 1'b1},
      '{rs: 1'b0, data: 8'h01, settle: 8'd8, poke: 1'b0},
      '{rs: 1'b0, data: 8'h02, settle: 8'd8, poke: 1'b0},
      '{rs: 1'b0, data: 8'h03, settle: 8'd8, poke: 1'b0},
      '{rs: 1'b0, data: 8'h04, settle: 8'd4, poke: 1'b1}
    };

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_sf_d", sf_d, 4'h0);
    check("rst_e", lcd_e, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_rw", lcd_rw, 1'b0);

    // Power-on init with req low.
    push_init();
    rel_cyc = cyc;
    rst_n   = 1'b1;
    wait_init("init1");

    // Data write, clear/home and ordinary command settle lengths.
    for (int i = 0; i < 5; i++) send(vecs[i]);

    // Back-to-back with req held; data changes on the done cycle.
    wait_ready("b2b_ready");
    push_byte(1'b1, 8'h48, T_40US);
    rs   = 1'b1;
    data = 8'h48;
    req  = 1'b1;
    tick();
    check("b2b_first_accept", ready, 1'b0);
    wait_done("b2b_done1");
    push_byte(1'b1, 8'h49, T_40US);
    data = 8'h49;
    tick();
    check("b2b_second_accept", ready, 1'b0);
    check("b2b_second_upper", sf_d, 4'h4);
    req = 1'b0;
    wait_done("b2b_done2");

    // Reset while E is high, then rerun init with req held from reset.
    wait_ready("midrst_ready");
    push_byte(1'b1, 8'h4F, T_40US);
    rs   = 1'b1;
    data = 8'h4F;
    req  = 1'b1;
    tick();
    req = 1'b0;
    begin
      int n = 0;
      while (!lcd_e && n < 50) begin
        tick();
        n++;
      end
    end
    check("midrst_e_high_before", lcd_e, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_e", lcd_e, 1'b0);
    check("midrst_ready", ready, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_init_done", init_done, 1'b0);
    check("midrst_sf_d", sf_d, 4'h0);
    check("midrst_rs", lcd_rs, 1'b0);
    check("midrst_rw", lcd_rw, 1'b0);
    exp_nib_q.delete();
    exp_done_q.delete();

    rs   = 1'b1;
    data = 8'h55;
    req  = 1'b1;
    repeat (3) tick();
    push_init();
    push_byte(1'b1, 8'h55, T_40US);
    rel_cyc = cyc;
    rst_n   = 1'b1;
    wait_init("init2");
    tick();
    check("early_req_accept", ready, 1'b0);
    check("early_req_upper", sf_d, 4'h5);
    req = 1'b0;
    wait_done("early_req_done");

    repeat (20) tick();
    check("nib_queue_drained", exp_nib_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
